// File: rtl/space_pkg.sv
// Shared Space Invaders screen constants and shooter state encoding.
// Pure declarations: no logic, no timing.
package space_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SHSIZE   = 16;
    localparam int X_MIN    = 16;
    localparam int X_MAX    = SCREEN_W - 2 * SHSIZE;
    localparam int X_START  = (SCREEN_W - SHSIZE) / 2 - 0;
    localparam int Y_TOP    = SCREEN_H - 40;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        GAME_OVER = 2'd2
    } shooter_state_t;

endpackage

// File: rtl/btn_sync.sv
// Button synchronizer: 2-FF metastability chain plus a registered rising-edge pulse.
// level follows raw two edges later; rise is a one-cycle pulse one edge after level rises.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
        end
    end

    assign level = sync;

endmodule

// File: rtl/shooter_ctrl.sv
// Player shooter: per-frame movement with clamping, one-shot fire requests with cooldown, lives/dying/game-over.
// All outputs registered; fire_valid holds until fire_ready, withdrawn only when the shooter is hit.
module shooter_ctrl #(
    parameter int SHSIZE       = space_pkg::SHSIZE,
    parameter int X_MIN        = space_pkg::X_MIN,
    parameter int X_MAX        = space_pkg::X_MAX,
    parameter int X_START      = 312,
    parameter int Y_TOP        = space_pkg::Y_TOP,
    parameter int STEP         = 2,
    parameter int COOLDOWN     = 8,
    parameter int DYING_FRAMES = 64,
    parameter int LIVES        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       hit,
    output logic [9:0] shooter_left_x,
    output logic [9:0] shooter_top_y,
    output logic       shooter_visible,
    output logic       fire_valid,
    output logic [9:0] fire_x,
    input  logic       fire_ready,
    output logic [1:0] lives,
    output logic       game_over
);

    import space_pkg::*;

    localparam int CD_W = $clog2(COOLDOWN + 1);
    localparam int DC_W = $clog2(DYING_FRAMES + 1);

    localparam logic [9:0]      X_MIN_V   = 10'(X_MIN);
    localparam logic [9:0]      X_MAX_V   = 10'(X_MAX);
    localparam logic [9:0]      X_START_V = 10'(X_START);
    localparam logic [9:0]      HALF_V    = 10'(SHSIZE / 2);
    localparam logic [1:0]      LIVES_V   = 2'(LIVES);
    localparam logic [CD_W-1:0] CD_V      = CD_W'(COOLDOWN);
    localparam logic [DC_W-1:0] DF_V      = DC_W'(DYING_FRAMES);

    logic left_lvl, left_rise;
    logic right_lvl, right_rise;
    logic fire_lvl, fire_rise;

    btn_sync u_sync_left (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_left),
        .level (left_lvl),
        .rise  (left_rise)
    );

    btn_sync u_sync_right (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_right),
        .level (right_lvl),
        .rise  (right_rise)
    );

    btn_sync u_sync_fire (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_fire),
        .level (fire_lvl),
        .rise  (fire_rise)
    );

    shooter_state_t  state, state_n;
    logic [9:0]      x, x_n;
    logic            fv_n;
    logic [9:0]      fx_n;
    logic [CD_W-1:0] cooldown, cooldown_n;
    logic [DC_W-1:0] dcnt, dcnt_n;
    logic [1:0]      lives_n;
    logic            visible_n;
    logic            game_over_n;

    logic [10:0] x_inc, x_dec;
    logic [9:0]  x_right, x_left;
    logic        transfer;

    // 11-bit arithmetic so a step below zero or past 1023 cannot wrap before clamping.
    always_comb begin
        x_inc   = {1'b0, x} + 11'(STEP);
        x_dec   = {1'b0, x} - 11'(STEP);
        x_right = (x_inc > 11'(X_MAX)) ? X_MAX_V : x_inc[9:0];
        x_left  = (x_dec[10] || (x_dec < 11'(X_MIN))) ? X_MIN_V : x_dec[9:0];
    end

    assign transfer = fire_valid & fire_ready;

    always_comb begin
        state_n     = state;
        x_n         = x;
        fv_n        = fire_valid;
        fx_n        = fire_x;
        cooldown_n  = cooldown;
        dcnt_n      = dcnt;
        lives_n     = lives;
        visible_n   = shooter_visible;
        game_over_n = game_over;

        if (transfer) begin
            fv_n       = 1'b0;
            cooldown_n = CD_V;
        end else if (frame_tick && (cooldown != '0)) begin
            cooldown_n = cooldown - CD_W'(1);
        end

        case (state)
            ALIVE: begin
                if (hit) begin
                    lives_n   = lives - 2'd1;
                    fv_n      = 1'b0;
                    state_n   = DYING;
                    dcnt_n    = DF_V;
                    visible_n = DF_V[2];
                end else begin
                    if (frame_tick) begin
                        if (left_lvl && !right_lvl) begin
                            x_n = x_left;
                        end else if (right_lvl && !left_lvl) begin
                            x_n = x_right;
                        end
                    end
                    // A pending request also covers the same-cycle transfer case.
                    if (fire_rise && !fire_valid && (cooldown == '0)) begin
                        fv_n = 1'b1;
                        fx_n = x + HALF_V;
                    end
                end
            end

            DYING: begin
                if (frame_tick) begin
                    dcnt_n = dcnt - DC_W'(1);
                    if (dcnt_n == '0) begin
                        if (lives == 2'd0) begin
                            state_n     = GAME_OVER;
                            visible_n   = 1'b0;
                            game_over_n = 1'b1;
                        end else begin
                            state_n    = ALIVE;
                            x_n        = X_START_V;
                            cooldown_n = '0;
                            visible_n  = 1'b1;
                        end
                    end else begin
                        visible_n = dcnt_n[2];
                    end
                end
            end

            GAME_OVER: begin
                visible_n   = 1'b0;
                game_over_n = 1'b1;
            end

            default: begin
                state_n = ALIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ALIVE;
            x               <= X_START_V;
            fire_valid      <= 1'b0;
            fire_x          <= X_START_V + HALF_V;
            cooldown        <= '0;
            dcnt            <= '0;
            lives           <= LIVES_V;
            shooter_visible <= 1'b1;
            game_over       <= 1'b0;
        end else begin
            state           <= state_n;
            x               <= x_n;
            fire_valid      <= fv_n;
            fire_x          <= fx_n;
            cooldown        <= cooldown_n;
            dcnt            <= dcnt_n;
            lives           <= lives_n;
            shooter_visible <= visible_n;
            game_over       <= game_over_n;
        end
    end

    assign shooter_left_x = x;
    assign shooter_top_y  = 10'(Y_TOP);

    // Edge pulses of the movement buttons are not needed; movement is level-driven.
    logic unused_rise;
    assign unused_rise = left_rise ^ right_rise ^ fire_lvl;

endmodule

// File: tb/tb_shooter_ctrl.sv
// Scoreboard bench for shooter_ctrl: stimulus queues expected snapshots and transfers,
// a negedge monitor pops and compares them.
module tb_shooter_ctrl;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic       hit;
    logic       fire_ready;
    logic [9:0] shooter_left_x;
    logic [9:0] shooter_top_y;
    logic       shooter_visible;
    logic       fire_valid;
    logic [9:0] fire_x;
    logic [1:0] lives;
    logic       game_over;

    shooter_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .frame_tick      (frame_tick),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_fire        (btn_fire),
        .hit             (hit),
        .shooter_left_x  (shooter_left_x),
        .shooter_top_y   (shooter_top_y),
        .shooter_visible (shooter_visible),
        .fire_valid      (fire_valid),
        .fire_x          (fire_x),
        .fire_ready      (fire_ready),
        .lives           (lives),
        .game_over       (game_over)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       fv;
        logic [9:0] fx;
        logic [1:0] lv;
        logic       vis;
        logic       go;
    } snap_t;

    snap_t      exp_q[$];
    string      name_q[$];
    logic [9:0] xfer_q[$];

    int   vectors = 0;
    int   miscompares = 0;
    logic probe = 1'b0;
    logic done_chk = 1'b0;
    logic done_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        snap_t e;
        snap_t a;
        string n;
        logic [9:0] efx;
        if (probe) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL probe: got a probe with no expected snapshot queued");
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = '{x: shooter_left_x, y: shooter_top_y, fv: fire_valid, fx: fire_x,
                      lv: lives, vis: shooter_visible, go: game_over};
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s: got x=%0d y=%0d fv=%0d fx=%0d lives=%0d vis=%0d go=%0d, expected x=%0d y=%0d fv=%0d fx=%0d lives=%0d vis=%0d go=%0d",
                             n, a.x, a.y, a.fv, a.fx, a.lv, a.vis, a.go,
                             e.x, e.y, e.fv, e.fx, e.lv, e.vis, e.go);
                end
            end
        end
        if (fire_valid === 1'b1 && fire_ready === 1'b1) begin
            vectors++;
            if (xfer_q.size() == 0) begin
                miscompares++;
                $display("FAIL transfer: got unexpected transfer fire_x=%0d, expected none", fire_x);
            end else begin
                efx = xfer_q.pop_front();
                if (fire_x !== efx) begin
                    miscompares++;
                    $display("FAIL transfer: got fire_x=%0d, expected %0d", fire_x, efx);
                end
            end
        end
        if (done_chk && !done_seen) begin
            done_seen = 1'b1;
            vectors++;
            if (xfer_q.size() != 0 || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL drain: got %0d transfers and %0d snapshots outstanding, expected 0 and 0",
                         xfer_q.size(), exp_q.size());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic check(input string name, input logic [9:0] ex, input logic efv,
                         input logic [1:0] elv, input logic evis, input logic ego);
        snap_t s;
        s.x   = ex;
        s.y   = 10'd440;
        s.fv  = efv;
        s.fx  = 10'd320;
        s.lv  = elv;
        s.vis = evis;
        s.go  = ego;
        exp_q.push_back(s);
        name_q.push_back(name);
        probe = 1'b1;
        cyc(1);
        probe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_fire = 1'b0; hit = 1'b0; fire_ready = 1'b0;
        do_reset();
        check("reset_state", 10'd312, 1'b0, 2'd3, 1'b1, 1'b0);

        // Movement and clamping
        btn_right = 1'b1; cyc(3);
        frame();
        check("right_one_step", 10'd314, 1'b0, 2'd3, 1'b1, 1'b0);
        btn_left = 1'b1; cyc(3);
        frames(3);
        check("both_held", 10'd314, 1'b0, 2'd3, 1'b1, 1'b0);
        btn_left = 1'b0; cyc(3);
        frames(399);
        check("right_clamp", 10'd608, 1'b0, 2'd3, 1'b1, 1'b0);
        btn_right = 1'b0; btn_left = 1'b1; cyc(3);
        frame();
        check("left_one_step", 10'd606, 1'b0, 2'd3, 1'b1, 1'b0);
        frames(399);
        check("left_clamp", 10'd16, 1'b0, 2'd3, 1'b1, 1'b0);
        btn_left = 1'b0; cyc(3);

        do_reset();
        check("reset_mid_op", 10'd312, 1'b0, 2'd3, 1'b1, 1'b0);

        // Single shot with backpressure, then cooldown
        btn_fire = 1'b1; cyc(5);
        check("fire_request", 10'd312, 1'b1, 2'd3, 1'b1, 1'b0);
        cyc(2);
        check("fire_held_stable", 10'd312, 1'b1, 2'd3, 1'b1, 1'b0);
        xfer_q.push_back(10'd320);
        fire_ready = 1'b1; cyc(1); fire_ready = 1'b0;
        check("fire_cleared", 10'd312, 1'b0, 2'd3, 1'b1, 1'b0);
        cyc(3);
        check("fire_hold_one_shot", 10'd312, 1'b0, 2'd3, 1'b1, 1'b0);
        btn_fire = 1'b0; cyc(3);
        frames(3);
        btn_fire = 1'b1; cyc(5);
        check("fire_in_cooldown", 10'd312, 1'b0, 2'd3, 1'b1, 1'b0);
        btn_fire = 1'b0; cyc(3);
        frames(6);
        btn_fire = 1'b1; cyc(5);
        check("fire_after_cooldown", 10'd312, 1'b1, 2'd3, 1'b1, 1'b0);
        btn_fire = 1'b0;

        // Hit while requesting; blink and respawn
        hit = 1'b1; cyc(1); hit = 1'b0;
        check("hit_withdraw", 10'd312, 1'b0, 2'd2, 1'b0, 1'b0);
        btn_fire = 1'b1;
        frame();
        check("blink_on", 10'd312, 1'b0, 2'd2, 1'b1, 1'b0);
        frames(4);
        check("blink_off", 10'd312, 1'b0, 2'd2, 1'b0, 1'b0);
        frames(58);
        check("dying_last_frame", 10'd312, 1'b0, 2'd2, 1'b0, 1'b0);
        frame();
        check("respawn", 10'd312, 1'b0, 2'd2, 1'b1, 1'b0);
        btn_fire = 1'b0; cyc(3);

        // Hit coincident with frame tick while moving right
        btn_right = 1'b1; cyc(3);
        hit = 1'b1; frame_tick = 1'b1; cyc(1); hit = 1'b0; frame_tick = 1'b0;
        check("hit_with_tick", 10'd312, 1'b0, 2'd1, 1'b0, 1'b0);
        frames(64);
        check("respawn_2", 10'd312, 1'b0, 2'd1, 1'b1, 1'b0);
        btn_right = 1'b0; cyc(3);

        // Hit coincident with a completing transfer, then game over
        btn_fire = 1'b1; cyc(5);
        check("fire_before_last_hit", 10'd312, 1'b1, 2'd1, 1'b1, 1'b0);
        xfer_q.push_back(10'd320);
        hit = 1'b1; fire_ready = 1'b1; cyc(1); hit = 1'b0; fire_ready = 1'b0;
        btn_fire = 1'b0;
        check("hit_with_transfer", 10'd312, 1'b0, 2'd0, 1'b0, 1'b0);
        frames(64);
        check("game_over", 10'd312, 1'b0, 2'd0, 1'b0, 1'b1);
        btn_right = 1'b1; btn_fire = 1'b1; cyc(3);
        frames(3);
        hit = 1'b1; cyc(1); hit = 1'b0;
        cyc(3);
        check("game_over_ignores", 10'd312, 1'b0, 2'd0, 1'b0, 1'b1);
        btn_right = 1'b0; btn_fire = 1'b0; cyc(3);

        do_reset();
        check("reset_after_game_over", 10'd312, 1'b0, 2'd3, 1'b1, 1'b0);

        done_chk = 1'b1;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shooter_ctrl.md
# shooter_ctrl

Player-shooter controller for the Space Invaders datapath. Samples left/right/fire buttons, moves the shooter once per frame within screen limits, and issues bullet launch requests over a valid/ready handshake. Tracks lives and the dying/game-over sequence. Drives the shooter position and visibility consumed by the shooter pixel renderer and the bullet logic.

## Interface

**Parameters**
- `SHSIZE`, 16: shooter sprite width/height in pixels.
- `X_MIN`, 16: minimum `shooter_left_x`.
- `X_MAX`, 608: maximum `shooter_left_x`.
- `X_START`, 312: spawn `shooter_left_x`.
- `Y_TOP`, 440: constant `shooter_top_y`.
- `STEP`, 2: pixels moved per frame.
- `COOLDOWN`, 8: frames between accepted shots.
- `DYING_FRAMES`, 64: length of the dying sequence.
- `LIVES`, 3: initial lives, range 1..3.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse, once per frame at start of vblank.
- `btn_left`, `btn_right`, `btn_fire` in 1 each: raw asynchronous buttons, active-high.
- `hit` in 1: one-cycle pulse from collision logic, meaning an alien bullet struck the shooter.
- `shooter_left_x` out 10: sprite left edge.
- `shooter_top_y` out 10: sprite top edge, always `Y_TOP`.
- `shooter_visible` out 1: renderer gates `pixel_on` with this.
- `fire_valid` out 1: launch request.
- `fire_x` out 10: bullet column, `shooter_left_x + SHSIZE/2`.
- `fire_ready` in 1: bullet logic accepts the request.
- `lives` out 2: remaining lives.
- `game_over` out 1: high in `GAME_OVER`.

## Operation

- Each button passes through a 2-FF synchronizer. Fire additionally gets rising-edge detection.
- **FSM states:** `ALIVE`, `DYING`, `GAME_OVER`. Reset enters `ALIVE`.
- **`ALIVE`, movement on `frame_tick`:**
  - Left only: x = max(x − STEP, X_MIN).
  - Right only: x = min(x + STEP, X_MAX).
  - Both or neither: no change.
  - Arithmetic is done in 11 bits, so no wrap-around occurs.
- **Fire:**
  - A fire rising edge in `ALIVE` with `cooldown==0` and `fire_valid==0` sets `fire_valid`.
  - `fire_x` is captured from the current x and held stable while valid.
  - Transfer happens on `fire_valid && fire_ready`. Then `fire_valid` clears and `cooldown` loads `COOLDOWN`.
  - `cooldown` decrements on each `frame_tick` while nonzero.
  - A fire edge that arrives while valid, while cooling down, or outside `ALIVE` is dropped, not queued.
  - Holding fire produces exactly one request.
- **`hit` in `ALIVE`:**
  - lives −1.
  - `fire_valid` is withdrawn next cycle. This is the only permitted withdrawal.
  - Go to `DYING` with the frame counter = `DYING_FRAMES`.
- **`DYING`:**
  - No movement, no fire, `hit` ignored.
  - Counter decrements per `frame_tick`.
  - `shooter_visible` = counter[2], so it blinks every 4 frames.
  - When the counter reaches 0:
    - If lives==0, go to `GAME_OVER`.
    - Otherwise go to `ALIVE` with x = `X_START` and cooldown = 0.
- **`GAME_OVER`:**
  - `shooter_visible`=0, `game_over`=1, all inputs ignored.
  - Exit only via `reset`.
- **Simultaneous events:**
  - `hit` and a fire transfer in the same cycle: the transfer completes (cooldown loaded), then `DYING`.
  - `hit` and `frame_tick` in the same cycle: hit wins, no movement that frame.
  - Fire edge and a transfer in the same cycle: the edge is dropped.
- **Reset mid-operation:** all state returns to reset values in the next cycle, regardless of FSM state or pending handshake.

## Timing

- All outputs are registered.
- **Reset values:**
  - `shooter_left_x`=`X_START`, `shooter_top_y`=`Y_TOP`.
  - `fire_valid`=0, `fire_x`=`X_START+SHSIZE/2`.
  - `shooter_visible`=1, `lives`=`LIVES`, `game_over`=0.
  - Internal: cooldown=0, dying counter=0, synchronizer flops=0.
- `frame_tick` in cycle t gives the updated `shooter_left_x` in t+1.
- Raw button change sampled at edge n is seen by logic at n+2. `fire_valid` rises at n+3.
- `fire_valid` falls the cycle after the handshake. A new request is possible no earlier than `COOLDOWN` frame_ticks later.
- `hit` at t gives `lives`/`shooter_visible` updated at t+1.
- Position holds between frame ticks, so the renderer sees a constant position for the whole active frame.

## Structure

- Shared package `space_pkg`:
  - Screen constants (640x480, `Y_TOP`, `X_MIN`/`X_MAX`).
  - Shooter state enum {`ALIVE`, `DYING`, `GAME_OVER`}.
  - `SHSIZE`.
- Sub-module `btn_sync`: 2-FF synchronizer plus registered previous value, giving `level` and `rise` outputs. Instantiated three times.

## Test plan

- **Move and clamp:** hold right for 400 frame_ticks → x saturates at 608. Hold left for 400 frame_ticks → x saturates at 16. Both held → x unchanged.
- **Single shot and cooldown:** press fire at x=312 with `fire_ready`=0 for 5 cycles → `fire_valid`=1, `fire_x`=320 stable. Raise ready → one transfer. Press again 3 frames later → dropped. Press at 9 frames → accepted.
- **Hit while requesting:** `fire_valid`=1, pulse `hit` → `fire_valid`=0 next cycle, lives 3→2, visible blinks with period 8 frames.
- **Respawn:** after 64 frame_ticks in `DYING` → `ALIVE`, x=312, visible=1.
- **Game over:** three hits with full dying sequences → lives=0, `game_over`=1, visible=0. Buttons have no effect. `reset` → lives=3, x=312.
- **Simultaneous:** `hit` and `frame_tick` with right held → x unchanged. `hit` coincident with `fire_ready` handshake → transfer counted, then `DYING`.
